// File: rtl/eth_test_pkg.sv
// Shared definitions for the Ethernet test-pattern checker and any future generator:
// FSM states, pattern modes, status bit positions, PRBS-9 polynomial and seed.
package eth_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_INCR  = 1'b0,
    MODE_PRBS9 = 1'b1
  } mode_t;

  localparam int STAT_DATA  = 0;
  localparam int STAT_LEN   = 1;
  localparam int STAT_TUSER = 2;
  localparam int STAT_MAC   = 3;

  localparam logic [3:0] STATUS_DROP = 4'b0001 << STAT_MAC;

  // x^9 + x^5 + 1: output bit is s[8], feedback s[8] ^ s[4] shifted in at s[0]
  localparam int         PRBS9_TAP_HI = 8;
  localparam int         PRBS9_TAP_LO = 4;
  localparam logic [8:0] PRBS9_SEED   = 9'h1FF;

  function automatic logic [8:0] prbs9_step8(input logic [8:0] s);
    logic [8:0] v;
    v = s;
    for (int k = 0; k < 8; k++) begin
      v = {v[7:0], v[PRBS9_TAP_HI] ^ v[PRBS9_TAP_LO]};
    end
    return v;
  endfunction

  // First generated bit lands in the MSB of the byte.
  function automatic logic [7:0] prbs9_byte(input logic [8:0] s);
    logic [8:0] v;
    logic [7:0] b;
    v = s;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      b[7-k] = v[PRBS9_TAP_HI];
      v = {v[7:0], v[PRBS9_TAP_HI] ^ v[PRBS9_TAP_LO]};
    end
    return b;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/eth_test_pattern_gen.sv
// Expected-byte source: presents the next KEEP_WIDTH pattern bytes (lane 0 first)
// and advances by a variable number of bytes so partial beats stay in sequence.
module eth_test_pattern_gen
  import eth_test_pkg::*;
#(
  parameter int KEEP_WIDTH = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_init,
  input  logic                               i_mode,
  input  logic                               i_advance,
  input  logic [$clog2(KEEP_WIDTH+1)-1:0]    i_count,
  output logic [KEEP_WIDTH*8-1:0]            o_bytes
);

  logic [8:0] r_lfsr;
  logic [7:0] r_idx;
  logic [8:0] w_lfsr_chain [KEEP_WIDTH+1];

  assign w_lfsr_chain[0] = r_lfsr;

  // Each lane sees the LFSR state one byte further along than the lane below it.
  generate
    for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
      assign w_lfsr_chain[gi+1] = prbs9_step8(w_lfsr_chain[gi]);
      assign o_bytes[8*gi +: 8] = (i_mode == MODE_PRBS9) ? prbs9_byte(w_lfsr_chain[gi])
                                                         : r_idx + 8'(gi);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= PRBS9_SEED;
      r_idx  <= '0;
    end else if (i_init) begin
      r_lfsr <= PRBS9_SEED;
      r_idx  <= '0;
    end else if (i_advance) begin
      r_lfsr <= w_lfsr_chain[i_count];
      r_idx  <= r_idx + 8'(i_count);
    end
  end

endmodule

// File: rtl/eth_test_checker.sv
// Receive-side test checker: filters frames by MAC pair, verifies the payload
// against an incrementing or PRBS-9 pattern and keeps saturating statistics.
module eth_test_checker
  import eth_test_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_00,
  parameter logic [47:0] PEER_MAC   = 48'h02_00_00_00_00_00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_mode,
  input  logic [15:0]           cfg_length,
  input  logic                  cfg_clear,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic                  frame_done,
  output logic [3:0]            frame_status,
  output logic [31:0]           ok_count,
  output logic [31:0]           err_count,
  output logic [31:0]           drop_count,
  output logic [31:0]           byte_count
);

  localparam int CW = $clog2(KEEP_WIDTH + 1);

  state_t                r_state, w_state_next;
  logic                  r_mode;
  logic [15:0]           r_len;
  logic [16:0]           r_cnt;
  logic                  r_err_data, r_err_len;
  logic                  r_done;
  logic [3:0]            r_status;
  logic [31:0]           r_ok_count, r_err_count, r_drop_count, r_byte_count;

  logic                  w_hdr_hs, w_pay_hs, w_frame_end, w_in_check, w_mac_match;
  logic [CW-1:0]         w_keep_cnt;
  logic [16:0]           w_cnt_next;
  logic                  w_beat_len_err;
  logic [3:0]            w_check_status;
  logic [KEEP_WIDTH-1:0] w_lane_err;
  logic [KEEP_WIDTH*8-1:0] w_exp;
  logic                  w_unused;

  // The EtherType plays no part in test traffic.
  assign w_unused    = ^s_eth_type;
  assign w_mac_match = (s_eth_dest_mac == LOCAL_MAC) && (s_eth_src_mac == PEER_MAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next              = r_state;
    s_eth_hdr_ready           = 1'b0;
    s_eth_payload_axis_tready = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        s_eth_hdr_ready = 1'b1;
        if (s_eth_hdr_valid) w_state_next = w_mac_match ? ST_CHECK : ST_DROP;
      end
      ST_CHECK, ST_DROP: begin
        s_eth_payload_axis_tready = 1'b1;
        if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_hdr_hs    = s_eth_hdr_valid && s_eth_hdr_ready;
  assign w_pay_hs    = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
  assign w_frame_end = w_pay_hs && s_eth_payload_axis_tlast;
  assign w_in_check  = (r_state == ST_CHECK);

  always_comb begin
    w_keep_cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      w_keep_cnt = w_keep_cnt + CW'(s_eth_payload_axis_tkeep[i]);
    end
  end

  eth_test_pattern_gen #(
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_pattern_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_init    (w_hdr_hs),
    .i_mode    (r_mode),
    .i_advance (w_pay_hs && w_in_check),
    .i_count   (w_keep_cnt),
    .o_bytes   (w_exp)
  );

  generate
    for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_cmp
      assign w_lane_err[gi] = s_eth_payload_axis_tkeep[gi] &&
                              (s_eth_payload_axis_tdata[8*gi +: 8] != w_exp[8*gi +: 8]);
    end
  endgenerate

  assign w_cnt_next     = r_cnt + 17'(w_keep_cnt);
  assign w_beat_len_err = !s_eth_payload_axis_tlast &&
                          (!(&s_eth_payload_axis_tkeep) || (w_cnt_next > {1'b0, r_len}));

  // Status of a checked frame, as it stands on its tlast beat.
  always_comb begin
    w_check_status             = '0;
    w_check_status[STAT_DATA]  = r_err_data || (|w_lane_err);
    w_check_status[STAT_LEN]   = r_err_len || (w_cnt_next != {1'b0, r_len});
    w_check_status[STAT_TUSER] = s_eth_payload_axis_tuser;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= 1'b0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_err_data <= 1'b0;
      r_err_len  <= 1'b0;
      r_done     <= 1'b0;
      r_status   <= '0;
    end else begin
      r_done   <= w_frame_end;
      r_status <= '0;
      if (w_hdr_hs) begin
        r_mode     <= cfg_mode;
        r_len      <= cfg_length;
        r_cnt      <= '0;
        r_err_data <= 1'b0;
        r_err_len  <= 1'b0;
      end
      if (w_pay_hs && w_in_check) begin
        r_cnt      <= w_cnt_next;
        r_err_data <= r_err_data || (|w_lane_err);
        r_err_len  <= r_err_len || w_beat_len_err;
      end
      if (w_frame_end) r_status <= w_in_check ? w_check_status : STATUS_DROP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ok_count   <= '0;
      r_err_count  <= '0;
      r_drop_count <= '0;
      r_byte_count <= '0;
    end else if (cfg_clear) begin
      r_ok_count   <= '0;
      r_err_count  <= '0;
      r_drop_count <= '0;
      r_byte_count <= '0;
    end else begin
      if (w_frame_end && w_in_check && (w_check_status == 4'b0000))
        r_ok_count <= sat_add(r_ok_count, 32'd1);
      if (w_frame_end && w_in_check && (w_check_status != 4'b0000))
        r_err_count <= sat_add(r_err_count, 32'd1);
      if (w_frame_end && (r_state == ST_DROP))
        r_drop_count <= sat_add(r_drop_count, 32'd1);
      if (w_pay_hs && w_in_check)
        r_byte_count <= sat_add(r_byte_count, 32'(w_keep_cnt));
    end
  end

  assign frame_done   = r_done;
  assign frame_status = r_status;
  assign ok_count     = r_ok_count;
  assign err_count    = r_err_count;
  assign drop_count   = r_drop_count;
  assign byte_count   = r_byte_count;

endmodule

// File: doc/eth_test_checker.md
ETH_TEST_CHECKER -- requirements
Module: eth_test_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload bus width in bits, legal 8/16/32/64.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, bytes per beat.
REQ-003 SHALL have parameter LOCAL_MAC, default 48'h02_00_00_00_00_00, expected destination MAC.
REQ-004 SHALL have parameter PEER_MAC, default 48'h02_00_00_00_00_00, expected source MAC.
REQ-005 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: cfg_mode  in  1  0 = incrementing byte, 1 = PRBS-9; cfg_length  in  16  expected payload bytes (1..65535); cfg_clear  in  1  synchronous counter clear.
REQ-008 SHALL have ports: s_eth_hdr_valid in 1, s_eth_hdr_ready out 1, s_eth_dest_mac in 48, s_eth_src_mac in 48, s_eth_type in 16.
REQ-009 SHALL have ports: s_eth_payload_axis_tdata in DATA_WIDTH, _tkeep in KEEP_WIDTH, _tvalid in 1, _tready out 1, _tlast in 1, _tuser in 1.
REQ-010 SHALL have ports: frame_done out 1 per-frame pulse; frame_status out 4 {mac, tuser, length, data} error bits; ok_count, err_count, drop_count, byte_count out 32 each.

Function
REQ-011 SHALL implement FSM IDLE, CHECK, DROP; hdr_ready high only in IDLE, payload tready high only in CHECK or DROP.
REQ-012 SHALL on header handshake in IDLE go to CHECK if dest==LOCAL_MAC and src==PEER_MAC, else DROP; s_eth_type ignored.
REQ-013 SHALL sample cfg_mode and cfg_length at header handshake; changes mid-frame have no effect on that frame.
REQ-014 SHALL return to IDLE on the tlast handshake from CHECK or DROP; next header accepted earliest the following cycle.
REQ-015 SHALL treat byte i of beat as lane i (tdata[8i+7:8i]); tkeep contiguous from lane 0; valid bytes = popcount(tkeep).
REQ-016 SHALL compare every valid byte in CHECK: mode 0 expected = frame byte index mod 256, starting 0 per frame; mode 1 expected = successive PRBS-9 (x^9+x^5+1) output bytes, seed 9'h1FF per frame, MSB first.
REQ-017 SHALL set data error on any valid-byte mismatch; invalid lanes never compared.
REQ-018 SHALL set length error if: non-last beat has tkeep not all-ones; running byte count exceeds cfg_length before tlast; or total at tlast != cfg_length.
REQ-019 SHALL continue consuming after a length overrun until tlast (no early exit).
REQ-020 SHALL set tuser error if tuser high on the tlast beat.
REQ-021 SHALL assert frame_done for exactly one cycle, the cycle after the tlast handshake, with frame_status valid only then.
REQ-022 SHALL in DROP discard payload unchecked, then pulse frame_done with status 4'b1000 and increment drop_count only.
REQ-023 SHALL increment ok_count (status 0) or err_count (status != 0) for CHECK frames on the edge that asserts frame_done.
REQ-024 SHALL add valid bytes of every CHECK-state payload handshake to byte_count.
REQ-025 SHALL saturate all counters at 32'hFFFF_FFFF.
REQ-026 SHALL on cfg_clear zero all counters; clear wins over a simultaneous increment; FSM unaffected.

Reset
REQ-027 SHALL on rst_n low force IDLE, hdr_ready 1, tready 0, frame_done 0, frame_status 0, all counters 0, PRBS state 9'h1FF.
REQ-028 SHALL on reset mid-frame abandon the frame with no frame_done and no counter update.

Structure
REQ-029 SHALL place mode encodings, frame_status bit positions, PRBS-9 taps and seed in shared package eth_test_pkg.
REQ-030 SHALL instantiate one sub-module eth_test_pattern_gen producing KEEP_WIDTH expected bytes per advance, reusable by a future generator.

Verification
REQ-031 SHALL cover: DATA_WIDTH=8, mode 0, cfg_length=64, matching MACs, bytes 0..63 with tlast on 64th -> frame_done, status 0, ok_count 1, byte_count 64.
REQ-032 SHALL cover: DATA_WIDTH=32, mode 1, cfg_length=30, 8 beats, last tkeep 4'b0011 -> status 0; flip one bit in beat 3 -> status 4'b0001, err_count 1.
REQ-033 SHALL cover: cfg_length=16, tlast after 20 bytes -> status 4'b0010; tlast after 12 bytes -> status 4'b0010; tready held until tlast.
REQ-034 SHALL cover: src_mac 48'h02_00_00_00_00_01 with 10 beats -> drop_count 1, ok/err/byte counts unchanged, status 4'b1000.
REQ-035 SHALL cover: ok_count preloaded to 32'hFFFF_FFFF via force -> next good frame keeps it saturated; cfg_clear same cycle as frame_done -> all counters 0.
REQ-036 SHALL cover: rst_n low at beat 5 of 64 -> no frame_done, counters 0, next full frame passes with status 0.
